fakeram_rr_arbiter: RTL and testbench
=====================================

# fakeram_rr_arbiter

Two-requester round-robin arbiter and sequencer for a single-port fakeram45 macro (default 32 words x 32 bits). It multiplexes read and write requests from two clients onto the macro's `ce`/`we`/`addr`/`wd`/`w_mask` pins. It tracks the one-cycle read latency of `rd_out` and returns read data to the issuing requester through a per-requester response register with valid/ready backpressure. It sits directly between cache/tag logic and one macro, replacing ad-hoc dual-port emulation wrappers.

## Interface
- ADDR_W, 5, word address width (depth = 2**ADDR_W)
- DATA_W, 32, data and write-mask width
- clk  in  1  single clock; macro shares this clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  2  request valid, bit r = requester r
- req_we_i  in  2  1 = write, 0 = read
- req_addr_i  in  2*ADDR_W  requester r at bits [r*ADDR_W +: ADDR_W]
- req_wdata_i  in  2*DATA_W  write data, same packing
- req_wmask_i  in  2*DATA_W  per-bit write enable, 1 = write bit
- req_ready_o  out  2  grant; a request is accepted when valid&ready
- resp_valid_o  out  2  read data available for requester r
- resp_data_o  out  2*DATA_W  registered read data
- resp_ready_i  in  2  requester r consumes its response
- mem_ce_o  out  1  macro chip enable, active-high
- mem_we_o  out  1  macro write enable, active-high
- mem_addr_o  out  ADDR_W  macro address
- mem_wd_o  out  DATA_W  macro write data
- mem_wmask_o  out  DATA_W  macro bit write mask
- mem_rd_i  in  DATA_W  macro read data, valid the cycle after a read
- busy_o  out  1  any read in flight or any response pending

## Operation
- **State:**
  - inflight_q[1:0]: read issued last cycle, per requester.
  - resp_valid_q[1:0] and resp_data_q[r]: response registers.
  - last_q: index of the last granted requester.
- **Eligibility of requester r:**
  - Requires req_valid_i[r].
  - Writes need no further condition.
  - Reads additionally need !inflight_q[r] && (!resp_valid_q[r] || resp_ready_i[r]).
- **Arbitration (combinational, same cycle):**
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one != last_q.
  - At most one bit of req_ready_o is high. req_ready_o is never high without req_valid_i.
- **Memory drive:**
  - On a grant to r: mem_ce_o=1, mem_we_o=req_we_i[r], mem_addr_o=addr[r].
  - On a granted write: mem_wd_o=wdata[r], mem_wmask_o=wmask[r].
  - On a granted read: mem_wd_o=0, mem_wmask_o=0.
  - With no grant, all mem_* outputs are 0.
- **Sequencing on the clock edge after a grant to r:**
  - last_q <= r.
  - If the grant was a read, inflight_q[r] <= 1; otherwise inflight_q[r] <= 0.
- **Response capture:** if inflight_q[r], then resp_data_q[r] <= mem_rd_i and resp_valid_q[r] <= 1.
- **Response drain:**
  - resp_valid_q[r] clears when resp_valid_o[r] && resp_ready_i[r] and no capture for r occurs that cycle.
  - If a capture occurs that same cycle, capture wins and valid stays 1.
  - resp_data_q[r] holds its value while valid and no capture occurs.
- **Writes:** complete with no response. A read after a write to the same address, granted in a later cycle, returns the new data.
- **busy_o** = |inflight_q | |resp_valid_q.

## Timing
- Reset values:
  - resp_valid_o=0, resp_data_o=0, inflight_q=0, busy_o=0.
  - last_q=1, so requester 0 wins the first tie.
  - All mem_* outputs follow the combinational rules above (all 0 when no request is valid).
- Read latency: accept in cycle T; resp_valid_o rises at the start of cycle T+2 (captured at the T+1→T+2 edge).
- Per-requester read issue rate is at most 1 per 2 cycles. Two requesters interleaving keep the macro busy every cycle.
- Write throughput is 1 per cycle per requester when uncontended. Writes are never blocked by a pending response.
- Backpressure: with resp_ready_i[r]=0 and resp_valid_o[r]=1, further reads from r stall. Writes from r and all traffic from the other requester proceed.
- Reset asserted mid-operation:
  - In-flight reads and pending responses are dropped; no response is produced.
  - The macro contents are not cleared.
- Simultaneous drain and new grant for r in one cycle is legal; the new response arrives 2 cycles later.

## Test plan
- Reset, then requester 0 writes 0xDEADBEEF to addr 3 with mask 0xFFFFFFFF, then reads addr 3 -> resp_valid_o[0]=1 two cycles after read accept, resp_data_o[0]=0xDEADBEEF.
- Both requesters hold continuous writes to addrs 0..7 -> grants alternate 0,1,0,1 starting with 0; mem_ce_o=1 every cycle.
- Write 0xFFFFFFFF to addr 5, then write 0x00000000 to addr 5 with mask 0x0000FFFF, then read -> data 0xFFFF0000.
- Requester 1 read with resp_ready_i[1]=0 held for 5 cycles while requester 1 keeps requesting reads -> no second read grant to 1; requester 0 reads still granted; resp_data_o[1] stable. On ready, drain; the next read is accepted the same cycle.
- Both requesters issue reads every cycle with resp_ready_i=2'b11 -> each receives a response every 2 cycles and the macro is utilized 100%.
- Assert rst one cycle after a read accept -> resp_valid_o stays 0 after release and busy_o=0.

Source files
------------

// File: rtl/fakeram_rr_arbiter.sv
// Two-requester round-robin front end for one single-port fakeram macro.
// It issues reads and writes onto the macro and returns read data through per-requester response registers.
module fakeram_rr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid_i,
    input  logic [1:0]            req_we_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    input  logic [2*DATA_W-1:0]   req_wmask_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            resp_valid_o,
    output logic [2*DATA_W-1:0]   resp_data_o,
    input  logic [1:0]            resp_ready_i,
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wd_o,
    output logic [DATA_W-1:0]     mem_wmask_o,
    input  logic [DATA_W-1:0]     mem_rd_i,
    output logic                  busy_o
);

    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][DATA_W-1:0] wdata_v;
    logic [1:0][DATA_W-1:0] wmask_v;

    logic [1:0]             inflight_q, inflight_d;
    logic [1:0]             resp_valid_q, resp_valid_d;
    logic [1:0][DATA_W-1:0] resp_data_q, resp_data_d;
    logic                   last_q, last_d;

    logic [1:0]             eligible;
    logic [1:0]             grant;
    logic                   gnt_idx;

    assign addr_v  = req_addr_i;
    assign wdata_v = req_wdata_i;
    assign wmask_v = req_wmask_i;

    // A read may only issue once the previous read has landed and its response slot is free or draining.
    always_comb begin
        eligible = 2'b00;
        for (int r = 0; r < 2; r++) begin
            eligible[r] = req_valid_i[r] &
                          (req_we_i[r] | (~inflight_q[r] & (~resp_valid_q[r] | resp_ready_i[r])));
        end
        grant = eligible;
        if (&eligible) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    assign gnt_idx     = grant[1];
    assign req_ready_o = grant;

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wd_o    = '0;
        mem_wmask_o = '0;
        if (|grant) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = req_we_i[gnt_idx];
            mem_addr_o = addr_v[gnt_idx];
            if (req_we_i[gnt_idx]) begin
                mem_wd_o    = wdata_v[gnt_idx];
                mem_wmask_o = wmask_v[gnt_idx];
            end
        end
    end

    // A landing read always wins over a same-cycle drain of the older response.
    always_comb begin
        last_d       = (|grant) ? gnt_idx : last_q;
        inflight_d   = grant & ~req_we_i;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        for (int r = 0; r < 2; r++) begin
            if (inflight_q[r]) begin
                resp_valid_d[r] = 1'b1;
                resp_data_d[r]  = mem_rd_i;
            end else if (resp_valid_q[r] && resp_ready_i[r]) begin
                resp_valid_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= 1'b1;
            inflight_q   <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
        end else begin
            last_q       <= last_d;
            inflight_q   <= inflight_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = (|inflight_q) | (|resp_valid_q);

endmodule

// File: tb/tb_fakeram_rr_arbiter.sv
// Bench for fakeram_rr_arbiter: a behavioural macro plus a transaction-level reference model
// (memory array and per-requester response queues) checked every cycle.
module tb_fakeram_rr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid_i = '0;
    logic [1:0]        req_we_i = '0;
    logic [2*AW-1:0]   req_addr_i = '0;
    logic [2*DW-1:0]   req_wdata_i = '0;
    logic [2*DW-1:0]   req_wmask_i = '0;
    logic [1:0]        req_ready_o;
    logic [1:0]        resp_valid_o;
    logic [2*DW-1:0]   resp_data_o;
    logic [1:0]        resp_ready_i = '0;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wd_o;
    logic [DW-1:0]     mem_wmask_o;
    logic [DW-1:0]     mem_rd_i;
    logic              busy_o;

    always #5 clk = ~clk;

    fakeram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wd_o(mem_wd_o), .mem_wmask_o(mem_wmask_o), .mem_rd_i(mem_rd_i),
        .busy_o(busy_o)
    );

    // Behavioural single-port macro: bit-masked write, registered read.
    bit [DW-1:0] macro_mem [2**AW];
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o)
                macro_mem[mem_addr_o] <= (macro_mem[mem_addr_o] & ~mem_wmask_o) | (mem_wd_o & mem_wmask_o);
            else
                mem_rd_i <= macro_mem[mem_addr_o];
        end
    end

    typedef struct {
        int          rdy;
        logic [DW-1:0] data;
    } resp_t;

    bit [DW-1:0] ref_mem [2**AW];
    resp_t       rq0[$];
    resp_t       rq1[$];
    int          cyc = 0;
    int          last_win = 1;
    logic [DW-1:0] hold [2];
    logic [1:0]  vis, infl, elig, exp_grant;
    logic [1:0]  obs_ready;
    logic        obs_ce;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        rq0.delete();
        rq1.delete();
        hold[0] = '0;
        hold[1] = '0;
        last_win = 1;
    endtask

    // Expected behaviour derived from the queued transactions: a response becomes visible two
    // cycles after its read was accepted and disappears when the requester takes it.
    task automatic checkOutput();
        int g;
        vis[0]  = (rq0.size() > 0) && (rq0[0].rdy <= cyc);
        vis[1]  = (rq1.size() > 0) && (rq1[0].rdy <= cyc);
        infl[0] = (rq0.size() > 0) && (rq0[rq0.size()-1].rdy > cyc);
        infl[1] = (rq1.size() > 0) && (rq1[rq1.size()-1].rdy > cyc);
        for (int r = 0; r < 2; r++)
            elig[r] = req_valid_i[r] && (req_we_i[r] || (!infl[r] && (!vis[r] || resp_ready_i[r])));
        if (elig == 2'b11) exp_grant = (last_win == 1) ? 2'b01 : 2'b10;
        else               exp_grant = elig;
        if (vis[0]) hold[0] = rq0[0].data;
        if (vis[1]) hold[1] = rq1[0].data;

        obs_ready = req_ready_o;
        obs_ce    = mem_ce_o;
        chk("ready", req_ready_o, exp_grant);
        chk("resp_valid", resp_valid_o, vis);
        chk("resp_data", resp_data_o, {hold[1], hold[0]});
        chk("busy", busy_o, (rq0.size() > 0 || rq1.size() > 0));
        g = exp_grant[1] ? 1 : 0;
        if (exp_grant != 2'b00) begin
            chk("mem_ce", mem_ce_o, 1'b1);
            chk("mem_we", mem_we_o, req_we_i[g]);
            chk("mem_addr", mem_addr_o, req_addr_i[g*AW +: AW]);
            chk("mem_wd", mem_wd_o, req_we_i[g] ? req_wdata_i[g*DW +: DW] : '0);
            chk("mem_wmask", mem_wmask_o, req_we_i[g] ? req_wmask_i[g*DW +: DW] : '0);
        end else begin
            chk("mem_idle", {mem_ce_o, mem_we_o, mem_addr_o, mem_wd_o[15:0], mem_wmask_o[15:0]}, '0);
        end
    endtask

    task automatic modelUpdate();
        int      g;
        int      a;
        resp_t   e;
        if (vis[0] && resp_ready_i[0]) void'(rq0.pop_front());
        if (vis[1] && resp_ready_i[1]) void'(rq1.pop_front());
        if (exp_grant != 2'b00) begin
            g = exp_grant[1] ? 1 : 0;
            a = int'(req_addr_i[g*AW +: AW]);
            last_win = g;
            if (req_we_i[g]) begin
                ref_mem[a] = (ref_mem[a] & ~req_wmask_i[g*DW +: DW]) | (req_wdata_i[g*DW +: DW] & req_wmask_i[g*DW +: DW]);
            end else begin
                e.rdy  = cyc + 2;
                e.data = ref_mem[a];
                if (g == 0) rq0.push_back(e);
                else        rq1.push_back(e);
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive at the falling edge, check, let the rising edge happen, return at the next falling edge.
    task automatic applyStimulus(input logic r_v, input logic [1:0] v, input logic [1:0] we,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] m0, input logic [DW-1:0] m1,
                                 input logic [1:0] rr);
        rst          = r_v;
        req_valid_i  = v;
        req_we_i     = we;
        req_addr_i   = {a1, a0};
        req_wdata_i  = {d1, d0};
        req_wmask_i  = {m1, m0};
        resp_ready_i = rr;
        if (r_v) modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        if (!r_v) modelUpdate();
        else      cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] rr);
        applyStimulus(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, rr);
    endtask

    initial begin
        int i0, i1, r0cnt;
        @(negedge clk);

        // Reset state.
        applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        chk("rst_resp_valid", resp_valid_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);

        // Write then read back on requester 0.
        applyStimulus(1'b0, 2'b01, 2'b01, 5'd3, '0, 32'hDEADBEEF, '0, 32'hFFFFFFFF, '0, 2'b00);
        chk("wr0_grant", obs_ready, 2'b01);
        applyStimulus(1'b0, 2'b01, 2'b00, 5'd3, '0, '0, '0, '0, '0, 2'b00);
        idle(2'b00);
        idle(2'b00);
        chk("rd0_valid", resp_valid_o[0], 1'b1);
        chk("rd0_data", resp_data_o[DW-1:0], 32'hDEADBEEF);
        idle(2'b11);

        // Contended writes alternate starting with requester 0.
        applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, {i1 < 8, i0 < 8}, 2'b11, AW'(i0), AW'(i1),
                          $urandom, $urandom, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
            chk("alt_grant", obs_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("alt_ce", obs_ce, 1'b1);
            if (exp_grant[0]) i0++;
            if (exp_grant[1]) i1++;
        end

        // Partial-mask write on requester 1.
        applyStimulus(1'b0, 2'b10, 2'b10, '0, 5'd5, '0, 32'hFFFFFFFF, '0, 32'hFFFFFFFF, 2'b00);
        applyStimulus(1'b0, 2'b10, 2'b10, '0, 5'd5, '0, 32'h00000000, '0, 32'h0000FFFF, 2'b00);
        applyStimulus(1'b0, 2'b10, 2'b00, '0, 5'd5, '0, '0, '0, '0, 2'b00);
        idle(2'b00);
        idle(2'b00);
        chk("mask_valid", resp_valid_o[1], 1'b1);
        chk("mask_data", resp_data_o[2*DW-1:DW], 32'hFFFF0000);

        // Backpressure on requester 1 while requester 0 keeps reading.
        r0cnt = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, AW'(k), 5'd9, '0, '0, '0, '0, 2'b01);
            chk("bp_no_r1", obs_ready[1], 1'b0);
            chk("bp_hold", resp_data_o[2*DW-1:DW], 32'hFFFF0000);
            if (obs_ready[0]) r0cnt++;
        end
        chk("bp_r0_grants", r0cnt, 3);
        applyStimulus(1'b0, 2'b10, 2'b00, '0, 5'd9, '0, '0, '0, '0, 2'b10);
        chk("bp_drain_grant", obs_ready, 2'b10);

        // Both requesters reading every cycle keep the macro fully busy.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, AW'($urandom), AW'($urandom), '0, '0, '0, '0, 2'b11);
            chk("full_util", obs_ce, 1'b1);
        end
        idle(2'b11);
        idle(2'b11);
        idle(2'b11);

        // Reset right after a read accept drops the read.
        applyStimulus(1'b0, 2'b01, 2'b00, 5'd3, '0, '0, '0, '0, '0, 2'b11);
        applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b11);
        for (int k = 0; k < 3; k++) begin
            idle(2'b11);
            chk("rst_drop_valid", resp_valid_o, 2'b00);
            chk("rst_drop_busy", busy_o, 1'b0);
        end

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0)
                applyStimulus(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
            else
                applyStimulus(1'b0, 2'($urandom), 2'($urandom), AW'($urandom), AW'($urandom),
                              $urandom, $urandom, $urandom, $urandom,
                              {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
